// File: rtl/tcounter_b_if.sv
// Signal bundle between the timer prescaler/register block and the tcounter_b counter stage.
// The counter drives the *_o outputs and the state_dbg debug field; everything else is driven into it.
interface tcounter_b_if #(
    parameter int WIDTH = 32
);
    logic             tick_i;
    logic             enable_i;
    logic             clear_i;
    logic             mode_i;
    logic [WIDTH-1:0] compare_value_i;
    logic             write_counter_i;
    logic [WIDTH-1:0] counter_value_i;
    logic             irq_clr_i;
    logic [WIDTH-1:0] counter_value_o;
    logic             match_o;
    logic             irq_o;
    logic             running_o;
    logic [1:0]       state_dbg;

    modport slave (
        input  tick_i, enable_i, clear_i, mode_i, compare_value_i,
        input  write_counter_i, counter_value_i, irq_clr_i,
        output counter_value_o, match_o, irq_o, running_o, state_dbg
    );

    modport master (
        output tick_i, enable_i, clear_i, mode_i, compare_value_i,
        output write_counter_i, counter_value_i, irq_clr_i,
        input  counter_value_o, match_o, irq_o, running_o, state_dbg
    );
endinterface

// File: rtl/tcounter_b.sv
// Timer counter stage: counts prescaler ticks, matches against a programmable compare value,
// and supports continuous (auto-reload) and one-shot modes with a sticky interrupt.
module tcounter_b #(
    parameter int WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    tcounter_b_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             match_q, match_d;
    logic             irq_q, irq_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;

        unique case (state_q)
            IDLE: if (bus.enable_i) state_d = RUN;
            RUN:  if (!bus.enable_i) state_d = IDLE;
            DONE: begin
                if (!bus.enable_i)    state_d = IDLE;
                else if (bus.clear_i) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase

        // clear beats load, load beats tick; neither clear nor load ever evaluates a match.
        if (bus.clear_i) begin
            cnt_d = '0;
        end else if (bus.write_counter_i) begin
            cnt_d = bus.counter_value_i;
        end else if (state_q == RUN && bus.enable_i && bus.tick_i) begin
            if (cnt_q == bus.compare_value_i) begin
                match_d = 1'b1;
                if (bus.mode_i) state_d = DONE;
                else            cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A set wins over a clear arriving in the same cycle.
        irq_d = match_d | (irq_q & ~bus.irq_clr_i);
    end

    assign bus.counter_value_o = cnt_q;
    assign bus.match_o         = match_q;
    assign bus.irq_o           = irq_q;
    assign bus.running_o       = (state_q == RUN);
    assign bus.state_dbg       = state_q;
endmodule

// File: tb/tb_tcounter_b.sv
// Directed bench for tcounter_b: inputs change 1 time unit after a rising edge,
// outputs are checked at that same point so every value is the registered result of the prior edge.
module tb_tcounter_b;
    localparam int WIDTH = 32;

    logic clk_i;
    logic rst_i;
    int   pass_cnt;
    int   total_cnt;

    tcounter_b_if #(.WIDTH(WIDTH)) bus ();

    tcounter_b #(.WIDTH(WIDTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, observed time %0t, required end before 200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [WIDTH-1:0] cnt, input logic m,
                             input logic irq, input logic run);
        check({tag, ".cnt"}, bus.counter_value_o, cnt);
        check({tag, ".match"}, {{(WIDTH-1){1'b0}}, bus.match_o}, {{(WIDTH-1){1'b0}}, m});
        check({tag, ".irq"}, {{(WIDTH-1){1'b0}}, bus.irq_o}, {{(WIDTH-1){1'b0}}, irq});
        check({tag, ".run"}, {{(WIDTH-1){1'b0}}, bus.running_o}, {{(WIDTH-1){1'b0}}, run});
    endtask

    initial begin
        pass_cnt            = 0;
        total_cnt           = 0;
        rst_i               = 1'b1;
        bus.tick_i          = 1'b0;
        bus.enable_i        = 1'b0;
        bus.clear_i         = 1'b0;
        bus.mode_i          = 1'b0;
        bus.compare_value_i = '0;
        bus.write_counter_i = 1'b0;
        bus.counter_value_i = '0;
        bus.irq_clr_i       = 1'b0;

        step(2);
        check_out("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;

        // continuous, compare 3, tick every cycle; tick on the enabling cycle is ignored
        bus.compare_value_i = 32'd3;
        bus.enable_i        = 1'b1;
        bus.tick_i          = 1'b1;
        step();
        check_out("cont.en", 32'd0, 1'b0, 1'b0, 1'b1);
        step();
        check_out("cont.t1", 32'd1, 1'b0, 1'b0, 1'b1);
        step();
        check_out("cont.t2", 32'd2, 1'b0, 1'b0, 1'b1);
        step();
        check_out("cont.t3", 32'd3, 1'b0, 1'b0, 1'b1);
        step();
        check_out("cont.m1", 32'd0, 1'b1, 1'b1, 1'b1);
        step();
        check_out("cont.t5", 32'd1, 1'b0, 1'b1, 1'b1);
        step(2);
        check_out("cont.t7", 32'd3, 1'b0, 1'b1, 1'b1);
        step();
        check_out("cont.m2", 32'd0, 1'b1, 1'b1, 1'b1);

        bus.irq_clr_i = 1'b1;
        step();
        check_out("irqclr", 32'd1, 1'b0, 1'b0, 1'b1);
        bus.irq_clr_i = 1'b0;
        step(2);
        check("pre_sim_irq.cnt", bus.counter_value_o, 32'd3);

        // match and irq clear in the same cycle: set wins
        bus.irq_clr_i = 1'b1;
        step();
        check_out("match+clr", 32'd0, 1'b1, 1'b1, 1'b1);
        bus.irq_clr_i = 1'b0;

        // enable drop at counter 5
        bus.compare_value_i = 32'd10;
        step(5);
        check("en_drop.pre", bus.counter_value_o, 32'd5);
        bus.enable_i = 1'b0;
        step();
        check_out("en_drop", 32'd5, 1'b0, 1'b1, 1'b0);
        check("en_drop.state", {30'd0, bus.state_dbg}, 32'd0);
        step();
        check("en_drop.hold", bus.counter_value_o, 32'd5);
        bus.enable_i = 1'b1;
        step();
        check_out("re_en", 32'd5, 1'b0, 1'b1, 1'b1);
        step();
        check("re_en.t", bus.counter_value_o, 32'd6);

        // clear + load + matching tick together
        bus.compare_value_i = 32'd6;
        bus.clear_i         = 1'b1;
        bus.write_counter_i = 1'b1;
        bus.counter_value_i = 32'd9;
        step();
        check("all3.cnt", bus.counter_value_o, 32'd0);
        check("all3.match", {31'd0, bus.match_o}, 32'd0);
        bus.clear_i         = 1'b0;
        bus.write_counter_i = 1'b0;

        // load above compare, wrap without early match
        bus.compare_value_i = 32'd1;
        bus.tick_i          = 1'b0;
        bus.write_counter_i = 1'b1;
        bus.counter_value_i = 32'hFFFF_FFFE;
        step();
        check_out("load", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
        bus.write_counter_i = 1'b0;
        bus.tick_i          = 1'b1;
        step();
        check_out("wrap.t1", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
        step();
        check_out("wrap.t2", 32'd0, 1'b0, 1'b1, 1'b1);
        step();
        check_out("wrap.t3", 32'd1, 1'b0, 1'b1, 1'b1);
        step();
        check_out("wrap.m", 32'd0, 1'b1, 1'b1, 1'b1);

        // one-shot, compare 2, tick every 5 cycles
        bus.tick_i    = 1'b0;
        bus.irq_clr_i = 1'b1;
        step();
        bus.irq_clr_i = 1'b0;
        bus.clear_i   = 1'b1;
        step();
        bus.clear_i         = 1'b0;
        check_out("os.start", 32'd0, 1'b0, 1'b0, 1'b1);
        bus.mode_i          = 1'b1;
        bus.compare_value_i = 32'd2;
        bus.tick_i = 1'b1; step(); bus.tick_i = 1'b0;
        check("os.t1", bus.counter_value_o, 32'd1);
        step(4);
        bus.tick_i = 1'b1; step(); bus.tick_i = 1'b0;
        check_out("os.t2", 32'd2, 1'b0, 1'b0, 1'b1);
        step(4);
        bus.tick_i = 1'b1; step(); bus.tick_i = 1'b0;
        check_out("os.m", 32'd2, 1'b1, 1'b1, 1'b0);
        check("os.state", {30'd0, bus.state_dbg}, 32'd2);
        step(4);
        check("os.match_gone", {31'd0, bus.match_o}, 32'd0);
        bus.tick_i = 1'b1; step(); bus.tick_i = 1'b0;
        check_out("os.hold", 32'd2, 1'b0, 1'b1, 1'b0);
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        check_out("os.rearm", 32'd0, 1'b0, 1'b1, 1'b1);

        // asynchronous reset mid-cycle at counter 7 with irq set
        bus.mode_i          = 1'b0;
        bus.compare_value_i = 32'd20;
        bus.tick_i          = 1'b1;
        step(7);
        bus.tick_i = 1'b0;
        check_out("pre_rst", 32'd7, 1'b0, 1'b1, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check_out("async_rst", 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst_i = 1'b0;
        check_out("rst_hold", 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_out("post_rst.en", 32'd0, 1'b0, 1'b0, 1'b1);
        bus.tick_i = 1'b1;
        step();
        bus.tick_i = 1'b0;
        check("post_rst.t1", bus.counter_value_o, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
